texture_tiler: RTL and testbench

Pixel-pipeline stage between the VGA timing generator and the display pins. It tiles a 32×32 RGB565 texture ROM across the screen: it turns the current pixel position plus a per-frame scroll offset into a ROM address and drives the ROM's enable and reset pins. It takes the ROM's 16-bit texel, blanks it outside the visible area and emits it with hsync/vsync/de delayed to match. Scroll advances once per N frames, so the texture pans.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/texture_tiler_if.sv | 41 ++++
 rtl/sync_delay.sv | 30 +++
 rtl/texture_tiler.sv | 156 +++++++++++++++
 tb/tb_texture_tiler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pixel-pipeline definitions: RGB565 layout, texture defaults,
// sync polarity and the scroll FSM state type.
package vga_pkg;

   localparam int unsigned RGB_R_LSB = 11;
   localparam int unsigned RGB_R_W   = 5;
   localparam int unsigned RGB_G_LSB = 5;
   localparam int unsigned RGB_G_W   = 6;
   localparam int unsigned RGB_B_LSB = 0;
   localparam int unsigned RGB_B_W   = 5;

   localparam int unsigned TEX_BITS_DEF    = 5;
   localparam bit          SYNC_ACTIVE_DEF = 1'b0;

   typedef enum logic {
      StIdle,
      StStep
   } scroll_state_e;

   // Field order matches the RGB565 bit layout, so a 16-bit word casts directly.
   typedef struct packed {
      logic [RGB_R_W-1:0] r;
      logic [RGB_G_W-1:0] g;
      logic [RGB_B_W-1:0] b;
   } rgb565_t;

   function automatic rgb565_t rgb565_split(input logic [15:0] word);
      rgb565_t pix;
      pix.r = word[RGB_R_LSB +: RGB_R_W];
      pix.g = word[RGB_G_LSB +: RGB_G_W];
      pix.b = word[RGB_B_LSB +: RGB_B_W];
      return pix;
   endfunction

endpackage

// File: rtl/texture_tiler_if.sv
// Video-in, texture-ROM and pixel-out signal bundle of the texture tiler.
// master: the tiler itself; slave: timing generator / ROM / display side.
interface texture_tiler_if
   import vga_pkg::*;
#(
   parameter int unsigned HBITS    = 10,
   parameter int unsigned VBITS    = 10,
   parameter int unsigned TEX_BITS = TEX_BITS_DEF
);

   logic [HBITS-1:0]      x;
   logic [VBITS-1:0]      y;
   logic                  de_in;
   logic                  hs_in;
   logic                  vs_in;
   logic                  scroll_en;

   logic [2*TEX_BITS-1:0] tex_ad;
   logic                  tex_ce;
   logic                  tex_oce;
   logic                  tex_reset;
   logic [15:0]           tex_dout;

   logic [RGB_R_W-1:0]    r;
   logic [RGB_G_W-1:0]    g;
   logic [RGB_B_W-1:0]    b;
   logic                  hs;
   logic                  vs;
   logic                  de;

   modport master (
      input  x, y, de_in, hs_in, vs_in, scroll_en, tex_dout,
      output tex_ad, tex_ce, tex_oce, tex_reset, r, g, b, hs, vs, de
   );

   modport slave (
      output x, y, de_in, hs_in, vs_in, scroll_en, tex_dout,
      input  tex_ad, tex_ce, tex_oce, tex_reset, r, g, b, hs, vs, de
   );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register; every stage is loaded with RESET_VAL on reset.
module sync_delay #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/texture_tiler.sv
// Tiles a 2^TEX_BITS square RGB565 texture ROM across the screen with a
// frame-prescaled scroll offset; syncs are delayed to match the ROM pipeline.
module texture_tiler
   import vga_pkg::*;
#(
   parameter int unsigned TEX_BITS    = TEX_BITS_DEF,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int unsigned HBITS       = 10,
   parameter int unsigned VBITS       = 10,
   parameter int unsigned ROM_LAT     = 1,
   parameter bit          SYNC_ACTIVE = SYNC_ACTIVE_DEF,
   parameter int unsigned SCROLL_DX   = 1,
   parameter int unsigned SCROLL_DY   = 0,
   parameter int unsigned FRAME_DIV   = 4
) (
   input logic             clk,
   input logic             rst_n,
   texture_tiler_if.master bus
);

   localparam int unsigned LAT = 2 + ROM_LAT;
   localparam int unsigned FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [2:0]  SYNC_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

   logic [TEX_BITS-1:0]   scroll_x_q;
   logic [TEX_BITS-1:0]   scroll_y_q;
   logic [TEX_BITS-1:0]   u;
   logic [TEX_BITS-1:0]   v;
   logic [2*TEX_BITS-1:0] tex_ad_q;

   logic                  vs_prev_q;
   logic                  frame_evt;
   logic                  frame_go;
   logic                  frame_last;
   logic [FCW-1:0]        frame_cnt_q;

   scroll_state_e         state_q;
   scroll_state_e         state_d;
   logic                  scroll_step;

   logic [2:0]            sync_mid;
   logic                  hs_q;
   logic                  vs_q;
   logic                  de_q;
   rgb565_t               pix_q;

   logic                  unused_bits;

   // Texel coordinates: drop the scale bits, keep TEX_BITS, wrap with scroll.
   assign u = bus.x[SCALE_SHIFT +: TEX_BITS] + scroll_x_q;
   assign v = bus.y[SCALE_SHIFT +: TEX_BITS] + scroll_y_q;

   assign unused_bits = ^{bus.x, bus.y};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tex_ad_q <= '0;
      end else begin
         tex_ad_q <= {v, u};
      end
   end

   // Frame event: vs_in entering its active level.
   assign frame_evt  = (bus.vs_in == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
   assign frame_go   = frame_evt && bus.scroll_en;
   assign frame_last = (frame_cnt_q == FCW'(FRAME_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_prev_q   <= ~SYNC_ACTIVE;
         frame_cnt_q <= '0;
      end else begin
         vs_prev_q <= bus.vs_in;
         if (frame_go) begin
            frame_cnt_q <= frame_last ? '0 : frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (frame_go && frame_last) begin
               state_d = StStep;
            end
         end
         StStep:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      scroll_step = 1'b0;
      unique case (state_q)
         StStep:  scroll_step = 1'b1;
         default: scroll_step = 1'b0;
      endcase
   end

   // Updates land inside vsync, so a visible frame never sees two offsets.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scroll_x_q <= '0;
         scroll_y_q <= '0;
      end else if (scroll_step) begin
         scroll_x_q <= scroll_x_q + TEX_BITS'(SCROLL_DX);
         scroll_y_q <= scroll_y_q + TEX_BITS'(SCROLL_DY);
      end
   end

   // LAT-1 stages here; the last stage sits with the colour register below.
   sync_delay #(
      .WIDTH     (3),
      .DEPTH     (LAT - 1),
      .RESET_VAL (SYNC_RST)
   ) u_sync_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({bus.hs_in, bus.vs_in, bus.de_in}),
      .dout  (sync_mid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hs_q  <= ~SYNC_ACTIVE;
         vs_q  <= ~SYNC_ACTIVE;
         de_q  <= 1'b0;
         pix_q <= '0;
      end else begin
         {hs_q, vs_q, de_q} <= sync_mid;
         pix_q              <= sync_mid[0] ? rgb565_split(bus.tex_dout) : '0;
      end
   end

   assign bus.tex_ad    = tex_ad_q;
   assign bus.tex_ce    = rst_n;
   assign bus.tex_oce   = rst_n;
   assign bus.tex_reset = ~rst_n;

   assign bus.r  = pix_q.r;
   assign bus.g  = pix_q.g;
   assign bus.b  = pix_q.b;
   assign bus.hs = hs_q;
   assign bus.vs = vs_q;
   assign bus.de = de_q;

endmodule

// File: tb/tb_texture_tiler.sv
// Directed bench for texture_tiler: a reference scroll model fills scoreboard
// queues per driven cycle; a monitor pops and compares at the due cycle.
module tb_texture_tiler;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   texture_tiler_if #(.HBITS(10), .VBITS(10), .TEX_BITS(5)) bus ();

   texture_tiler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Texture ROM, bypass read mode: one cycle from address to data.
   logic [15:0] rom_q = 16'h0000;
   bit          rom_ones = 1'b0;

   function automatic logic [15:0] rom_fn(input logic [9:0] a);
      return {a, a[9:4]};
   endfunction

   always @(posedge clk) begin
      if (bus.tex_ce) rom_q <= rom_ones ? 16'hFFFF : rom_fn(bus.tex_ad);
   end
   assign bus.tex_dout = rom_q;

   typedef struct {
      int         due;
      logic [9:0] ad;
   } ad_exp_t;

   typedef struct {
      int          due;
      logic [18:0] px;
   } px_exp_t;

   ad_exp_t ad_q[$];
   px_exp_t px_q[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   int sx_m = 0;
   int sy_m = 0;
   int cnt_m = 0;
   bit pend_m = 1'b0;
   bit vsp_m = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Monitor: compare every scoreboard entry that falls due after this edge.
   initial begin
      ad_exp_t a;
      px_exp_t p;
      forever begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         while (ad_q.size() > 0 && ad_q[0].due <= cyc) begin
            a = ad_q.pop_front();
            chk("tex_ad", {22'd0, bus.tex_ad}, {22'd0, a.ad});
         end
         while (px_q.size() > 0 && px_q[0].due <= cyc) begin
            p = px_q.pop_front();
            chk("pixel{r,g,b,hs,vs,de}",
                {13'd0, bus.r, bus.g, bus.b, bus.hs, bus.vs, bus.de}, {13'd0, p.px});
         end
      end
   end

   task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs,
                        input bit en);
      int          k;
      logic [4:0]  u;
      logic [4:0]  v;
      logic [15:0] d;
      ad_exp_t     a;
      px_exp_t     p;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.x         = 10'(x);
      bus.y         = 10'(y);
      bus.de_in     = de;
      bus.hs_in     = hs;
      bus.vs_in     = vs;
      bus.scroll_en = en;
      k = cyc + 1;
      u = 5'((x >> 1) + sx_m);
      v = 5'((y >> 1) + sy_m);
      a.due = k;
      a.ad  = {v, u};
      ad_q.push_back(a);
      d = de ? rom_fn({v, u}) : 16'h0000;
      p.due = k + 2;
      p.px  = {d, hs, vs, de};
      px_q.push_back(p);
      // Scroll applies one edge after the event edge, so it affects the next drive.
      if (pend_m) begin
         sx_m   = (sx_m + 1) % 32;
         pend_m = 1'b0;
      end
      if (en && !vs && vsp_m) begin
         if (cnt_m == 3) begin
            cnt_m  = 0;
            pend_m = 1'b1;
         end else begin
            cnt_m++;
         end
      end
      vsp_m = vs;
   endtask

   task automatic reset_cycle();
      int      k;
      ad_exp_t a;
      px_exp_t p;
      @(negedge clk);
      rst_n = 1'b0;
      k = cyc + 1;
      a.due = k;
      a.ad  = '0;
      ad_q.push_back(a);
      while (px_q.size() > 0 && px_q[px_q.size()-1].due >= k) px_q.delete(px_q.size() - 1);
      for (int i = 0; i < 3; i++) begin
         p.due = k + i;
         p.px  = {16'h0000, 1'b1, 1'b1, 1'b0};
         px_q.push_back(p);
      end
      sx_m   = 0;
      sy_m   = 0;
      cnt_m  = 0;
      pend_m = 1'b0;
      vsp_m  = 1'b1;
      #1;
      chk("tex_ce_in_reset", {31'd0, bus.tex_ce}, 32'd0);
      chk("tex_oce_in_reset", {31'd0, bus.tex_oce}, 32'd0);
      chk("tex_reset_in_reset", {31'd0, bus.tex_reset}, 32'd1);
   endtask

   task automatic check_ad(input string tag, input int exp);
      @(posedge clk);
      #2;
      chk(tag, {22'd0, bus.tex_ad}, 32'(exp));
   endtask

   task automatic frame_event(input bit en);
      drive(0, 0, 1'b0, 1'b1, 1'b0, en);
      drive(0, 0, 1'b0, 1'b1, 1'b0, en);
      drive(0, 0, 1'b0, 1'b1, 1'b1, en);
      drive(0, 0, 1'b0, 1'b1, 1'b1, en);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int sweep_exp[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
      int guard;

      bus.x = '0;
      bus.y = '0;
      bus.de_in = 1'b0;
      bus.hs_in = 1'b1;
      bus.vs_in = 1'b1;
      bus.scroll_en = 1'b0;

      reset_cycle();
      reset_cycle();

      for (int i = 0; i < 8; i++) begin
         drive(i, 0, 1'b1, 1'b1, 1'b1, 1'b0);
         check_ad("sweep_tex_ad", sweep_exp[i]);
      end
      chk("tex_ce_running", {31'd0, bus.tex_ce}, 32'd1);
      chk("tex_reset_running", {31'd0, bus.tex_reset}, 32'd0);

      drive(70, 130, 1'b1, 1'b1, 1'b1, 1'b0);
      check_ad("x70_y130", 35);

      // Blanked region with an all-ones ROM plus hsync/vsync pulses.
      repeat (3) drive(5, 5, 1'b0, 1'b1, 1'b1, 1'b0);
      rom_ones = 1'b1;
      drive(6, 5, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(7, 5, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(8, 5, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(9, 5, 1'b0, 1'b1, 1'b1, 1'b0);
      rom_ones = 1'b0;
      repeat (3) drive(10, 5, 1'b0, 1'b1, 1'b1, 1'b0);

      // Nine enabled frame events: steps after the 4th and 8th.
      for (int e = 1; e <= 9; e++) begin
         frame_event(1'b1);
         drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
         check_ad("scroll_prescale", e / 4);
      end

      guard = 0;
      while (sx_m != 31 && guard < 200) begin
         frame_event(1'b1);
         guard++;
      end
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_ad("scroll_at_31", 31);
      repeat (4) frame_event(1'b1);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_ad("scroll_wrap", 0);

      // Prescaler must hold across disabled frames.
      repeat (2) frame_event(1'b1);
      repeat (5) frame_event(1'b0);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      check_ad("scroll_hold_disabled", 0);
      frame_event(1'b1);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_ad("scroll_cnt_held", 0);
      frame_event(1'b1);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_ad("scroll_after_resume", 1);

      // Mid-line reset.
      for (int i = 10; i < 14; i++) drive(i, 4, 1'b1, 1'b1, 1'b1, 1'b1);
      reset_cycle();
      for (int i = 14; i < 20; i++) drive(i, 4, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_ad("scroll_after_reset", 0);

      repeat (2) drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(ad_q.size() + px_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
